// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport integer register bank.
package regfile_pkg;

    // Sweep FSM encoding: INIT clears the bank, RUN accepts accesses.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

    // Upper bound on read ports supported by the bank.
    localparam int MAX_RD_PORTS = 4;

    // Number of registers addressed by a select of the given width.
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: alloc marks a register as awaiting a result,
// writeback clears it; a same-cycle alloc to the written register wins.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ready_i,
    input  logic                     alloc_en_i,
    input  logic [ADDR_W-1:0]        alloc_sel_i,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_sel_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel_i,
    output logic [NUM_RD-1:0]        rd_busy_o
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             set_ok;
    logic             clr_ok;

    // x0 never becomes busy when it is hardwired to zero.
    assign set_ok = ready_i && alloc_en_i && !((ZERO_REG != 0) && (alloc_sel_i == '0));
    assign clr_ok = ready_i && wr_en_i;

    // Next busy vector: clear first, then set, so a new producer overrides the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (clr_ok) begin
            busy_d[wr_sel_i] = 1'b0;
        end
        if (set_ok) begin
            busy_d[alloc_sel_i] = 1'b1;
        end
    end

    // Busy state register; reset empties the scoreboard and drops this edge's updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
        assign rd_busy_o[k] = busy_q[rd_sel_i[k*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/regfile_multiport.sv
// Integer register bank: NUM_RD combinational read ports, one write port,
// optional write-to-read forwarding, optional hardwired-zero x0, busy scoreboard,
// and a post-reset sweep that clears every register before accesses are accepted.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_sel,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_sel,
    output logic                     ready
);

    localparam int                DEPTH    = depth_of(ADDR_W);
    localparam logic [ADDR_W:0]   IDX_LAST = (ADDR_W + 1)'(DEPTH - 1);

    rf_state_e         state_q;
    logic [ADDR_W:0]   idx_q;
    logic              ready_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_ok;

    // A write lands only once the bank is live, outside reset, and not aimed at a hardwired x0.
    assign wr_ok = ready_q && wr_en && !rst && !((ZERO_REG != 0) && (wr_sel == '0));

    // Sweep FSM: walk idx across the bank once after reset, then raise ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Storage: cleared one entry per edge during the sweep, written by writeback afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem_q[idx_q[ADDR_W-1:0]] <= '0;
            end else if (wr_ok) begin
                mem_q[wr_sel] <= wr_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] sel;
        logic [DATA_W-1:0] data;

        assign sel = rd_sel[k*ADDR_W +: ADDR_W];

        // Read mux: zero until live, zero for hardwired x0, forwarded write data, else stored value.
        always_comb begin
            data = mem_q[sel];
            if (!ready_q) begin
                data = '0;
            end else if ((ZERO_REG != 0) && (sel == '0)) begin
                data = '0;
            end else if ((BYPASS != 0) && wr_ok && (wr_sel == sel)) begin
                data = wr_data;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .ready_i     (ready_q),
        .alloc_en_i  (alloc_en),
        .alloc_sel_i (alloc_sel),
        .wr_en_i     (wr_en),
        .wr_sel_i    (wr_sel),
        .rd_sel_i    (rd_sel),
        .rd_busy_o   (rd_busy)
    );

    assign ready = ready_q;

endmodule
